// File: rtl/clock_fnd_pkg.sv
// rtl/clock_fnd_pkg.sv - shared constants, snapshot type and font lookup for the FND controller
package clock_fnd_pkg;

  localparam int NUM_DIGITS       = 4;
  localparam int DP_BIT           = 7;
  localparam int DOT_BLINK_THRESH = 50;

  // Common-anode segment codes {dp,g,f,e,d,c,b,a}, active-low, dp off
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef struct packed {
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       mode;
  } snap_t;

  function automatic logic [7:0] font_of(input logic [3:0] digit);
    case (digit)
      4'd0:    font_of = FONT_0;
      4'd1:    font_of = FONT_1;
      4'd2:    font_of = FONT_2;
      4'd3:    font_of = FONT_3;
      4'd4:    font_of = FONT_4;
      4'd5:    font_of = FONT_5;
      4'd6:    font_of = FONT_6;
      4'd7:    font_of = FONT_7;
      4'd8:    font_of = FONT_8;
      4'd9:    font_of = FONT_9;
      default: font_of = FONT_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/clock_fnd_bcd.sv
// rtl/clock_fnd_bcd.sv - 7-bit binary to two-digit BCD, saturating at 99
module clock_fnd_bcd (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] sat;

  always_comb begin
    sat  = (bin > 7'd99) ? 7'd99 : bin;
    tens = 4'(sat / 7'd10);
    ones = 4'(sat % 7'd10);
  end

endmodule

// File: rtl/clock_fnd_ctrl.sv
// rtl/clock_fnd_ctrl.sv - four-digit multiplexed FND driver with per-frame time snapshot
// Optional build macro FND_DOT_BLINK_EN: blink the d2 decimal point at 1 Hz from snapshot msec.
module clock_fnd_ctrl
  import clock_fnd_pkg::*;
#(
  parameter int SCAN_COUNT = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       sw_mode,
  output logic [3:0] fnd_comm,
  output logic [7:0] fnd_font
);

  localparam int CW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int SW = $clog2(NUM_DIGITS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  snap_t         snap_q, snap_d;
  logic [3:0]    comm_q, comm_d;
  logic [7:0]    font_q, font_d;

  logic       scan_tick;
  logic       dp_lit;
  logic [6:0] left_bin, right_bin;
  logic [3:0] left_tens, left_ones, right_tens, right_ones;

  assign scan_tick = (cnt_q == CW'(SCAN_COUNT - 1));

  // Digit values always come from the snapshot so one frame never mixes two times
  always_comb begin
    left_bin  = snap_q.mode ? {1'b0, snap_q.sec} : {2'b00, snap_q.hour};
    right_bin = snap_q.mode ? snap_q.msec        : {1'b0, snap_q.min};
  end

  clock_fnd_bcd u_bcd_left (
    .bin  (left_bin),
    .tens (left_tens),
    .ones (left_ones)
  );

  clock_fnd_bcd u_bcd_right (
    .bin  (right_bin),
    .tens (right_tens),
    .ones (right_ones)
  );

`ifdef FND_DOT_BLINK_EN
  assign dp_lit = (snap_q.msec < 7'(DOT_BLINK_THRESH));
`else
  assign dp_lit = 1'b1;
`endif

  always_comb begin
    cnt_d  = scan_tick ? '0 : cnt_q + 1'b1;
    sel_d  = scan_tick ? sel_q + 1'b1 : sel_q;
    snap_d = snap_q;
    if (scan_tick && (sel_q == SW'(NUM_DIGITS - 1))) begin
      snap_d.msec = msec;
      snap_d.sec  = sec;
      snap_d.min  = min;
      snap_d.hour = hour;
      snap_d.mode = sw_mode;
    end

    comm_d = ~(4'b0001 << sel_q);
    case (sel_q)
      2'd0:    font_d = font_of(right_ones);
      2'd1:    font_d = font_of(right_tens);
      2'd2:    font_d = font_of(left_ones);
      default: font_d = font_of(left_tens);
    endcase
    if (sel_q == 2'd2) begin
      font_d[DP_BIT] = ~dp_lit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      snap_q <= '0;
      comm_q <= 4'b1111;
      font_q <= FONT_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      snap_q <= snap_d;
      comm_q <= comm_d;
      font_q <= font_d;
    end
  end

  assign fnd_comm = comm_q;
  assign fnd_font = font_q;

endmodule

// File: doc/clock_fnd_ctrl.md
# clock_fnd_ctrl

Four-digit seven-segment (FND) display controller. It consumes the hour/min/sec/msec time outputs of the clock datapath and drives a common-anode, time-multiplexed four-digit display. A mode input selects HH.MM or SS.CC view. The block snapshots the time fields once per display frame so that a single frame never mixes two different times.

## Interface
Parameters:
- SCAN_COUNT, 100_000: clock cycles per digit slot (1 kHz digit rate at 100 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- msec  in  7  centiseconds, binary
- sec  in  6  seconds, binary
- min  in  6  minutes, binary
- hour  in  5  hours, binary
- sw_mode  in  1  view select: 0 = HH.MM, 1 = SS.CC
- fnd_comm  out  4  digit enables, active-low; bit0 = rightmost digit
- fnd_font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low

## Operation
- Scan counter counts 0..SCAN_COUNT-1 and wraps. scan_tick is high for the one cycle in which the count equals SCAN_COUNT-1.
- On each scan_tick, digit_sel (2 bits) advances 0→1→2→3→0.
- Frame snapshot: on a scan_tick with digit_sel==3, msec, sec, min, hour and sw_mode are registered into the snapshot. All digits of the next frame use the snapshot only.
- Digit mapping for mode 0: d3 = hour tens, d2 = hour ones, d1 = min tens, d0 = min ones.
- Digit mapping for mode 1: d3 = sec tens, d2 = sec ones, d1 = msec tens, d0 = msec ones.
- Binary to BCD conversion: tens = v/10, ones = v%10. Any value above 99 (msec up to 127) saturates to 99. hour up to 31, sec and min up to 63 are shown as-is.
- Font codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp bit set = off).
- Decimal point is shown on d2 only. Its state is set by the configuration below.
- fnd_comm is exactly one-hot-low for the active digit.

## Timing
- Reset values (rst low at a clk edge):
  - scan count = 0, digit_sel = 0, snapshot = all zero
  - fnd_comm = 4'b1111, fnd_font = 8'hFF (display dark)
- Output stage is registered from digit_sel and the snapshot, with 1-cycle latency:
  - First cycle after reset release: fnd_comm = 4'b1110, fnd_font = 8'hC0.
  - Every digit change appears on the outputs 1 cycle after the digit_sel change.
- A new input value is visible starting with the first frame after the next digit_sel 3→0 wrap. Worst case is about 4·SCAN_COUNT+1 cycles.
- A sw_mode change mid-frame has no effect until the frame boundary.
- Reset asserted mid-frame: dark on the next edge. Scan restarts from digit 0 with zero snapshot.
- Inputs change freely. No handshake and no input validity qualifier.

## Configuration
- FND_DOT_BLINK_EN defined: d2 dp is lit while snapshot msec < 50 and dark otherwise, giving a 1 Hz blink.
- FND_DOT_BLINK_EN undefined: d2 dp is lit continuously.
- In both cases, dp on d0, d1 and d3 is always dark.

## Structure
- Shared package clock_fnd_pkg holds:
  - font constants FONT_0..FONT_9 and FONT_BLANK = 8'hFF
  - DP_BIT = 7
  - NUM_DIGITS = 4
  - DOT_BLINK_THRESH = 50
- One sub-module, clock_fnd_bcd: combinational, 7-bit binary in → 4-bit tens and 4-bit ones out, saturating at 99. Instantiated twice, once for the left field and once for the right field.

## Test plan
- SCAN_COUNT=4, reset, then inputs hour=12, min=34, mode 0:
  - Frame 1 shows 0000.
  - From frame 2: d3 = F9, d2 = A4 with dp lit (24 if blink and msec<50), d1 = B0, d0 = 99.
  - fnd_comm cycles 1110, 1101, 1011, 0111, each slot lasting 4 cycles.
- Mode 1 with sec=59, msec=7:
  - Shows 59.07: d3 = 92, d2 = 90 (with dp), d1 = C0, d0 = F8.
- msec=120 in mode 1: right field shows 99.
- sec changes from 10 to 11 at a cycle when digit_sel = 1: the current frame still shows 10 on every digit, and the next frame shows 11.
- Blink build:
  - msec=49: d2 font bit7 = 0.
  - msec=50: bit7 = 1 in the following frame.
- Non-blink build: bit7 = 0 on d2 for all msec.
- rst low mid-scan for 1 cycle:
  - Outputs 1111 / FF on the next edge.
  - After release: 1110 / C0, then normal scan from digit 0.
